// File: rtl/uio_byte_tx_if.sv
// Core-side byte port of uio_byte_tx: a plain valid/ready push interface.
// The core logic drives data/valid through the master modport and the
// transmitter answers with ready through the slave modport.
interface uio_byte_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/uio_byte_tx.sv
// Pin-side byte transmitter. Bytes pushed by core logic are queued in a small
// FIFO and presented one at a time on the uio pins. Each byte uses a 4-phase
// strobe/ack handshake with an external reader: data and oe settle, strobe
// rises, the reader raises ack, strobe falls, the reader drops ack, and the
// pins are released. A reader that never acks is timed out and flagged.
module uio_byte_tx #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  uio_byte_tx_if.slave           in_if,
  input  logic                   ena_i,
  input  logic                   ack_in_i,
  input  logic                   err_clr_i,
  output logic [7:0]             uio_out_o,
  output logic [7:0]             uio_oe_o,
  output logic                   strobe_o,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned SetW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [LvlW-1:0] LevelFull  = LvlW'(DEPTH);
  localparam logic [SetW-1:0] SetupLoad  = SetW'(SETUP_CYC - 1);
  localparam logic [TmoW-1:0] TimeoutEnd = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StRelease
  } state_e;

  // ---------------------------------------------------------------------------
  // ack synchronizer
  // ---------------------------------------------------------------------------
  logic ack_meta_q;
  logic ack_s_q;

  // Two-flop synchronizer; ack_in_i is driven by an external, unclocked reader.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= ack_in_i;
      ack_s_q    <= ack_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            nonempty_q;
  logic            push;
  logic            pop;
  logic            start;

  assign in_if.in_ready = (level_q != LevelFull);
  assign push           = in_if.in_valid && in_if.in_ready;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_if.in_data;
    end
  end

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end
  end

  // FIFO state registers. nonempty_q gives the start decision a registered
  // view of occupancy, so a freshly pushed byte starts one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      nonempty_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      nonempty_q <= (level_q != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic [7:0]      uio_out_q;
  logic [7:0]      uio_oe_q;
  logic            strobe_q;
  logic            err_q;
  logic [SetW-1:0] setup_cnt_q;
  logic [TmoW-1:0] tmo_cnt_q;

  // A stale ack still high from the reader holds off the next transfer.
  assign start = (state_q == StIdle) && nonempty_q && (level_q != '0) && ena_i && !ack_s_q;
  assign pop   = start;

  // Transfer sequencing with registered pin outputs and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      uio_out_q   <= 8'h00;
      uio_oe_q    <= 8'h00;
      strobe_q    <= 1'b0;
      err_q       <= 1'b0;
      setup_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      // A timeout below overrides this clear when both happen together.
      if (err_clr_i) begin
        err_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          uio_oe_q <= 8'h00;
          strobe_q <= 1'b0;
          if (start) begin
            uio_out_q   <= mem_q[rd_ptr_q];
            uio_oe_q    <= 8'hFF;
            setup_cnt_q <= SetupLoad;
            state_q     <= StSetup;
          end
        end
        StSetup: begin
          if (setup_cnt_q == '0) begin
            strobe_q  <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= StStrobe;
          end else begin
            setup_cnt_q <= setup_cnt_q - SetW'(1);
          end
        end
        StStrobe: begin
          if (ack_s_q) begin
            strobe_q <= 1'b0;
            state_q  <= StRelease;
          end else if (tmo_cnt_q == TimeoutEnd) begin
            // Reader never answered: drop the byte and free the pins.
            err_q    <= 1'b1;
            strobe_q <= 1'b0;
            uio_oe_q <= 8'h00;
            state_q  <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        StRelease: begin
          if (!ack_s_q) begin
            uio_oe_q <= 8'h00;
            state_q  <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign uio_out_o = uio_out_q;
  assign uio_oe_o  = uio_oe_q;
  assign strobe_o  = strobe_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != StIdle);
  assign level_o   = level_q;

endmodule

// File: tb/tb_uio_byte_tx.sv
// Directed bench for uio_byte_tx: single byte timing, FIFO fill, timeout,
// ena gating, reset mid-transfer and full-FIFO push/pop interaction.
module tb_uio_byte_tx;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       ack_in;
  logic       err_clr;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       strobe;
  logic       busy;
  logic       err;
  logic [2:0] level;

  int vectors;
  int miscompares;

  uio_byte_tx_if in_if ();

  uio_byte_tx #(
    .DEPTH    (4),
    .SETUP_CYC(2),
    .TIMEOUT  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_if    (in_if),
    .ena_i    (ena),
    .ack_in_i (ack_in),
    .err_clr_i(err_clr),
    .uio_out_o(uio_out),
    .uio_oe_o (uio_oe),
    .strobe_o (strobe),
    .busy_o   (busy),
    .err_o    (err),
    .level_o  (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit in case a wait loop is ever bypassed.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    in_if.in_data  = b;
    in_if.in_valid = 1'b1;
    tick(1);
    in_if.in_valid = 1'b0;
  endtask

  // Full reader-side handshake for one byte, every wait bounded.
  task automatic xfer(input logic [7:0] exp_b, input string tag);
    int n;
    n = 0;
    while (uio_oe !== 8'hFF && n < 40) begin tick(1); n++; end
    chk({tag, "_oe"}, 32'(uio_oe), 32'hFF);
    chk({tag, "_data"}, 32'(uio_out), 32'(exp_b));
    n = 0;
    while (strobe !== 1'b1 && n < 40) begin tick(1); n++; end
    chk({tag, "_stb_hi"}, 32'(strobe), 32'h1);
    ack_in = 1'b1;
    n = 0;
    while (strobe !== 1'b0 && n < 40) begin tick(1); n++; end
    chk({tag, "_stb_lo"}, 32'(strobe), 32'h0);
    chk({tag, "_oe_held"}, 32'(uio_oe), 32'hFF);
    ack_in = 1'b0;
    n = 0;
    while (uio_oe !== 8'h00 && n < 40) begin tick(1); n++; end
    chk({tag, "_oe_rel"}, 32'(uio_oe), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int bad;
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    ena            = 1'b0;
    ack_in         = 1'b0;
    err_clr        = 1'b0;
    in_if.in_data  = 8'h00;
    in_if.in_valid = 1'b0;

    // Reset values
    tick(2);
    chk("rst_oe", 32'(uio_oe), 32'h0);
    chk("rst_stb", 32'(strobe), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ready", 32'(in_if.in_ready), 32'h1);
    chk("rst_out", 32'(uio_out), 32'h0);
    rst = 1'b0;
    tick(2);

    // Single byte, exact edge timing
    ena = 1'b1;
    push(8'hA5);                            // push edge E0
    chk("s_lvl1", 32'(level), 32'h1);
    chk("s_oe_e0", 32'(uio_oe), 32'h0);
    tick(1);                                // E1
    chk("s_oe_e1", 32'(uio_oe), 32'h0);
    tick(1);                                // E2
    chk("s_oe_e2", 32'(uio_oe), 32'hFF);
    chk("s_out_e2", 32'(uio_out), 32'hA5);
    chk("s_busy", 32'(busy), 32'h1);
    chk("s_lvl0", 32'(level), 32'h0);
    tick(1);                                // E3
    chk("s_stb_e3", 32'(strobe), 32'h0);
    tick(1);                                // E4
    chk("s_stb_e4", 32'(strobe), 32'h1);
    ack_in = 1'b1;
    tick(2);
    chk("s_stb_a2", 32'(strobe), 32'h1);
    tick(1);
    chk("s_stb_a3", 32'(strobe), 32'h0);
    chk("s_oe_a3", 32'(uio_oe), 32'hFF);
    ack_in = 1'b0;
    tick(2);
    chk("s_oe_d2", 32'(uio_oe), 32'hFF);
    tick(1);
    chk("s_oe_d3", 32'(uio_oe), 32'h0);
    chk("s_busy_d3", 32'(busy), 32'h0);

    // FIFO fill with ena low; fifth byte refused
    ena = 1'b0;
    in_if.in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_if.in_data = 8'(i);
      tick(1);
    end
    in_if.in_valid = 1'b0;
    chk("f_level", 32'(level), 32'h4);
    chk("f_ready", 32'(in_if.in_ready), 32'h0);
    ena = 1'b1;
    xfer(8'h01, "f_b1");
    xfer(8'h02, "f_b2");
    xfer(8'h03, "f_b3");
    xfer(8'h04, "f_b4");
    tick(8);
    chk("f_no5_oe", 32'(uio_oe), 32'h0);
    chk("f_no5_lvl", 32'(level), 32'h0);

    // Timeout: strobe high 8 cycles, then abort with err
    push(8'h3C);
    tick(4);
    chk("t_stb_s0", 32'(strobe), 32'h1);
    chk("t_out", 32'(uio_out), 32'h3C);
    bad = 0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (strobe !== 1'b1) bad++;
    end
    chk("t_stb_held", 32'(bad), 32'h0);
    tick(1);
    chk("t_stb_drop", 32'(strobe), 32'h0);
    chk("t_oe_drop", 32'(uio_oe), 32'h0);
    chk("t_err", 32'(err), 32'h1);
    chk("t_busy", 32'(busy), 32'h0);
    push(8'h5A);
    xfer(8'h5A, "t_next");
    chk("t_err_kept", 32'(err), 32'h1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t_err_clr", 32'(err), 32'h0);

    // ena gating
    ena = 1'b0;
    push(8'h77);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (uio_oe !== 8'h00 || busy !== 1'b0) bad++;
    end
    chk("g_idle", 32'(bad), 32'h0);
    ena = 1'b1;
    xfer(8'h77, "g_b");

    // Reset mid-transfer, async release of pins
    ena = 1'b0;
    push(8'hC3);
    push(8'hD1);
    push(8'hD2);
    ena = 1'b1;
    tick(3);
    chk("r_stb", 32'(strobe), 32'h1);
    chk("r_out", 32'(uio_out), 32'hC3);
    chk("r_lvl2", 32'(level), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("r_oe_async", 32'(uio_oe), 32'h0);
    chk("r_stb_async", 32'(strobe), 32'h0);
    chk("r_lvl_async", 32'(level), 32'h0);
    tick(1);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (uio_oe !== 8'h00 || busy !== 1'b0) bad++;
    end
    chk("r_no_send", 32'(bad), 32'h0);

    // Full FIFO with pop and in_valid held: no push that cycle, next accepted
    ena = 1'b0;
    push(8'h10);
    push(8'h11);
    push(8'h12);
    push(8'h13);
    tick(1);
    chk("p_full", 32'(level), 32'h4);
    in_if.in_data  = 8'h14;
    in_if.in_valid = 1'b1;
    ena = 1'b1;
    tick(1);
    chk("p_lvl3", 32'(level), 32'h3);
    chk("p_ready", 32'(in_if.in_ready), 32'h1);
    chk("p_pop_out", 32'(uio_out), 32'h10);
    tick(1);
    in_if.in_valid = 1'b0;
    chk("p_lvl4", 32'(level), 32'h4);
    xfer(8'h10, "p_b0");
    xfer(8'h11, "p_b1");
    xfer(8'h12, "p_b2");
    xfer(8'h13, "p_b3");
    xfer(8'h14, "p_b4");
    chk("p_empty", 32'(level), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
